// File: rtl/vector_norm_nd_if.sv
// Handshake bundle for vector_norm_nd: vector in, length and sum of squares out.
// master = producer/consumer side, slave = the norm engine.
// Widths follow DIM/W exactly as the engine derives them.
interface vector_norm_nd_if #(
  parameter int DIM = 2,
  parameter int W   = 12
);
  localparam int SW = 2*W + $clog2(DIM);
  localparam int OW = (SW + 1) / 2;

  logic              in_valid;
  logic              in_ready;
  logic [DIM*W-1:0]  xin;
  logic              out_valid;
  logic              out_ready;
  logic [OW:0]       yout;
  logic [SW-1:0]     sumsq;
  logic              busy;

  modport master (
    output in_valid, xin, out_ready,
    input  in_ready, out_valid, yout, sumsq, busy
  );

  modport slave (
    input  in_valid, xin, out_ready,
    output in_ready, out_valid, yout, sumsq, busy
  );
endinterface

// File: rtl/vector_norm_nd.sv
// Euclidean length of a DIM-component vector: serial sum of squares, then bit-serial square root.
// Latency: result valid DIM+OW+1 edges after the accepting edge, independent of data.
// Backpressure: one vector in flight; in_ready stays low until the result is taken by out_ready.
module vector_norm_nd #(
  parameter int DIM    = 2,
  parameter int W      = 12,
  parameter int SIGNED = 0,
  parameter int ROUND  = 0
) (
  input  logic             clk,
  input  logic             rst,
  vector_norm_nd_if.slave  bus
);
  localparam int SW   = 2*W + $clog2(DIM);
  localparam int OW   = (SW + 1) / 2;
  localparam int PW   = 2*OW;          // radicand padded to an even number of bits
  localparam int RW   = OW + 3;        // partial remainder plus two shifted-in bits
  localparam int CMAX = (DIM > OW) ? DIM : OW;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] ACC_LAST = CW'(DIM - 1);
  localparam logic [CW-1:0] SQ_LAST  = CW'(OW);

  typedef enum logic [1:0] {IDLE, ACC, SQRT, DONE} state_t;

  state_t            state;
  logic [DIM*W-1:0]  xreg;
  logic [SW-1:0]     acc;
  logic [PW-1:0]     sreg;
  logic [RW-1:0]     rem;
  logic [OW-1:0]     root;
  logic [CW-1:0]     cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [OW:0]       yout_q;
  logic [SW-1:0]     sumsq_q;

  logic [W-1:0]      comp;
  logic [W-1:0]      mag;
  logic [2*W-1:0]    sq;
  logic [SW-1:0]     acc_nx;
  logic [RW-1:0]     rem_sh;
  logic [RW-1:0]     trial;
  logic              ge;
  logic              rnd;

  // Datapath: magnitude-square of the current component and one restoring root step.
  // Squaring the magnitude keeps -2^(W-1) exact: its magnitude still fits in W unsigned bits.
  always_comb begin
    comp   = xreg[W-1:0];
    mag    = (SIGNED != 0 && comp[W-1]) ? (~comp + W'(1)) : comp;
    sq     = {{W{1'b0}}, mag} * {{W{1'b0}}, mag};
    acc_nx = acc + SW'(sq);
    rem_sh = {rem[RW-3:0], sreg[PW-1 -: 2]};
    trial  = RW'({root, 2'b01});
    ge     = (rem_sh >= trial);
    rnd    = (ROUND != 0) && (rem > RW'(root));
  end

  // Control FSM with all outputs registered; the extra SQRT cycle applies rounding and loads the results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      xreg        <= '0;
      acc         <= '0;
      sreg        <= '0;
      rem         <= '0;
      root        <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      yout_q      <= '0;
      sumsq_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            xreg       <= bus.xin;
            acc        <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ACC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ACC: begin
          acc  <= acc_nx;
          xreg <= xreg >> W;
          if (cnt == ACC_LAST) begin
            sreg  <= PW'(acc_nx);
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            state <= SQRT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SQRT: begin
          if (cnt == SQ_LAST) begin
            yout_q      <= (OW+1)'(root) + (OW+1)'(rnd);
            sumsq_q     <= acc;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            rem  <= ge ? (rem_sh - trial) : rem_sh;
            root <= (root << 1) | OW'(ge);
            sreg <= sreg << 2;
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.yout      = yout_q;
  assign bus.sumsq     = sumsq_q;
endmodule
